operand_launcher: RTL and testbench

Input-side stage that feeds the bit-counting controller/datapath pair. Synchronises and debounces the raw start switch and operand switches, latches one 8-bit operand per press, and drives the controller's start signal `s` with a full four-phase handshake against `done`. Tracks completed runs and flags a hung run with a watchdog. Sits between the board switches and the `controller_RTL`/`Datapath_RTL` pair.

---
 rtl/operand_launcher.sv | 159 +++++++++++++++
 tb/tb_operand_launcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_launcher.sv
// Input-side launcher: synchronises and debounces the start/operand switches, latches one
// operand per press and runs a four-phase s/done handshake with a watchdog and run counter.
module operand_launcher #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic       clock,
   input  logic       reset_b,
   input  logic       start_sw,
   input  logic [7:0] data_sw,
   input  logic       done,
   output logic       s,
   output logic [7:0] data_A,
   output logic       busy,
   output logic       timeout,
   output logic [7:0] run_count
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_RELEASE = 2'd2,
      ST_FAULT   = 2'd3
   } state_t;

   logic            r_start_meta;
   logic            r_start_sync;
   logic [7:0]      r_data_meta;
   logic [7:0]      r_data_sync;
   logic [DB_W-1:0] r_db_cnt;
   logic            r_start_db;
   logic            r_start_db_q;
   logic            w_start_edge;

   state_t          r_state;
   logic            r_s;
   logic            r_busy;
   logic [7:0]      r_data_a;
   logic            r_timeout;
   logic [7:0]      r_run_count;
   logic [WD_W-1:0] r_wd;

   // Two-flop synchronisers for the asynchronous switch inputs
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_start_meta <= 1'b0;
         r_start_sync <= 1'b0;
         r_data_meta  <= 8'd0;
         r_data_sync  <= 8'd0;
      end else begin
         r_start_meta <= start_sw;
         r_start_sync <= r_start_meta;
         r_data_meta  <= data_sw;
         r_data_sync  <= r_data_meta;
      end
   end

   // Debounce: the synchronised level must disagree for DEBOUNCE_CYCLES straight cycles
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_db_cnt     <= '0;
         r_start_db   <= 1'b0;
         r_start_db_q <= 1'b0;
      end else begin
         r_start_db_q <= r_start_db;
         if (r_start_sync == r_start_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_start_db <= r_start_sync;
            r_db_cnt   <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
         end
      end
   end

   assign w_start_edge = r_start_db & ~r_start_db_q;

   // Launch/handshake FSM; s and busy are registered alongside the next state
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_state     <= ST_IDLE;
         r_s         <= 1'b0;
         r_busy      <= 1'b0;
         r_data_a    <= 8'd0;
         r_timeout   <= 1'b0;
         r_run_count <= 8'd0;
         r_wd        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_edge) begin
                  r_data_a  <= r_data_sync;
                  r_timeout <= 1'b0;
                  r_wd      <= '0;
                  r_state   <= ST_RUN;
                  r_s       <= 1'b1;
                  r_busy    <= 1'b1;
               end else begin
                  r_s    <= 1'b0;
                  r_busy <= 1'b0;
               end
            end
            ST_RUN: begin
               r_wd <= r_wd + WD_ONE;
               // done takes priority over a watchdog expiry in the same cycle
               if (done) begin
                  r_state     <= ST_RELEASE;
                  r_run_count <= r_run_count + 8'd1;
                  r_s         <= 1'b0;
               end else if (r_wd == WD_LAST) begin
                  r_state   <= ST_FAULT;
                  r_timeout <= 1'b1;
                  r_s       <= 1'b0;
               end else begin
                  r_s <= 1'b1;
               end
            end
            ST_RELEASE: begin
               r_s <= 1'b0;
               if (!done) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_busy <= 1'b1;
               end
            end
            ST_FAULT: begin
               r_s <= 1'b0;
               if (!done && !r_start_db) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_busy <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_s     <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign s         = r_s;
   assign data_A    = r_data_a;
   assign busy      = r_busy;
   assign timeout   = r_timeout;
   assign run_count = r_run_count;

endmodule

// File: tb/tb_operand_launcher.sv
// Directed bench for operand_launcher with a small debounce/timeout and a hand-driven
// controller model on done.
module tb_operand_launcher;

   logic       clock;
   logic       reset_b;
   logic       start_sw;
   logic [7:0] data_sw;
   logic       done;
   logic       s;
   logic [7:0] data_A;
   logic       busy;
   logic       timeout;
   logic [7:0] run_count;

   int checks   = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;
   int exp_runs = 0;
   int lat;
   int s_cyc;
   int seen;

   operand_launcher #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock    (clock),
      .reset_b  (reset_b),
      .start_sw (start_sw),
      .data_sw  (data_sw),
      .done     (done),
      .s        (s),
      .data_A   (data_A),
      .busy     (busy),
      .timeout  (timeout),
      .run_count(run_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive operand and press; return number of negedges until s is seen high (bounded)
   task automatic press(input logic [7:0] d, output int l);
      data_sw  = d;
      start_sw = 1'b1;
      l = 0;
      while (s !== 1'b1 && l < 20) begin
         @(negedge clock);
         l++;
      end
   endtask

   // Controller model: raise done on the done_at-th cycle of s (0 = never); count s cycles
   task automatic run_until_fall(input int done_at, output int sc);
      sc = 1;
      if (done_at == sc) done = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (s !== 1'b1) break;
         sc++;
         if (done_at == sc) done = 1'b1;
      end
   endtask

   task automatic release_sw();
      start_sw = 1'b0;
      repeat (10) @(negedge clock);
   endtask

   initial begin
      reset_b  = 1'b0;
      start_sw = 1'b0;
      data_sw  = 8'h00;
      done     = 1'b0;
      #12;
      chk("rst_s", s, 1'b0);
      chk("rst_data", data_A, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_count", run_count, 8'h00);
      @(negedge clock);
      reset_b = 1'b1;
      repeat (3) @(negedge clock);

      // Basic launch, 9-cycle handshake, held switch gives one launch
      press(8'hA5, lat);
      chk("launch_s", s, 1'b1);
      chk("launch_latency_ok", (lat >= 6 && lat <= 9), 1'b1);
      chk("launch_data", data_A, 8'hA5);
      chk("launch_busy", busy, 1'b1);
      run_until_fall(9, s_cyc);
      chk("s_high_cycles", s_cyc, 9);
      exp_runs = (exp_runs + 1) % 256;
      chk("count_after_run1", run_count, exp_runs);
      chk("busy_in_release", busy, 1'b1);
      done = 1'b0;
      @(negedge clock);
      chk("busy_after_release", busy, 1'b0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (busy !== 1'b0) seen++;
      end
      chk("held_no_relaunch", seen, 0);
      release_sw();

      // Short glitch: no launch
      start_sw = 1'b1;
      repeat (3) @(negedge clock);
      start_sw = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (s !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("glitch_no_launch", seen, 0);
      chk("glitch_count", run_count, exp_runs);

      // Operand held through RUN; changes only on the next launch
      press(8'h0F, lat);
      chk("launch2_s", s, 1'b1);
      data_sw = 8'hFF;
      run_until_fall(3, s_cyc);
      chk("data_held_run", data_A, 8'h0F);
      exp_runs = (exp_runs + 1) % 256;
      done = 1'b0;
      repeat (5) @(negedge clock);
      chk("data_held_idle", data_A, 8'h0F);
      release_sw();
      press(8'hFF, lat);
      chk("launch3_s", s, 1'b1);
      chk("data_next_launch", data_A, 8'hFF);
      run_until_fall(2, s_cyc);
      exp_runs = (exp_runs + 1) % 256;
      done = 1'b0;
      @(negedge clock);
      release_sw();
      chk("count_after_run3", run_count, exp_runs);

      // Watchdog: done never comes
      press(8'h3C, lat);
      chk("launch4_s", s, 1'b1);
      run_until_fall(0, s_cyc);
      chk("timeout_s_cycles", s_cyc, 16);
      chk("timeout_flag", timeout, 1'b1);
      chk("fault_busy", busy, 1'b1);
      chk("fault_count", run_count, exp_runs);
      repeat (10) @(negedge clock);
      chk("fault_hold_busy", busy, 1'b1);
      release_sw();
      chk("fault_exit_busy", busy, 1'b0);
      chk("timeout_sticky", timeout, 1'b1);

      // Relaunch clears timeout; done coincides with watchdog expiry
      press(8'h5A, lat);
      chk("launch5_s", s, 1'b1);
      chk("timeout_cleared", timeout, 1'b0);
      run_until_fall(16, s_cyc);
      chk("tie_s_cycles", s_cyc, 16);
      exp_runs = (exp_runs + 1) % 256;
      chk("tie_count", run_count, exp_runs);
      chk("tie_timeout", timeout, 1'b0);
      done = 1'b0;
      @(negedge clock);
      chk("tie_release_idle", busy, 1'b0);
      release_sw();

      // Run up to 255, then wrap
      while (exp_runs < 255) begin
         press(8'h11, lat);
         run_until_fall(1, s_cyc);
         exp_runs = exp_runs + 1;
         done = 1'b0;
         @(negedge clock);
         start_sw = 1'b0;
         repeat (8) @(negedge clock);
      end
      chk("count_255", run_count, 8'd255);
      press(8'h22, lat);
      run_until_fall(1, s_cyc);
      exp_runs = (exp_runs + 1) % 256;
      chk("count_wrap", run_count, 8'd0);
      done = 1'b0;
      @(negedge clock);
      release_sw();

      // Asynchronous reset during RUN
      press(8'h99, lat);
      repeat (3) @(negedge clock);
      chk("pre_reset_s", s, 1'b1);
      #2;
      reset_b = 1'b0;
      #1;
      chk("mid_rst_s", s, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_data", data_A, 8'h00);
      chk("mid_rst_count", run_count, 8'h00);
      chk("mid_rst_timeout", timeout, 1'b0);
      start_sw = 1'b0;
      @(negedge clock);
      reset_b = 1'b1;
      repeat (10) @(negedge clock);
      chk("post_rst_idle", busy, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, checks);
      $finish;
   end

endmodule
